// File: rtl/ap_ctrl_seq_pkg.sv
// Shared types and helpers for the ap_ctrl_hs transaction sequencer.
package ap_ctrl_seq_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  // Width able to hold 0..max_out inclusive.
  function automatic int clog2_outstanding(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/ap_ctrl_txn_counter.sv
// Saturating up-counter with synchronous clear; stops at max_i.
module ap_ctrl_txn_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q < max_i)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives ap_ctrl_hs of one HLS kernel for a programmed number of overlapping transactions.
// Optional watchdog: define AP_CTRL_SEQ_WATCHDOG_EN.
module ap_ctrl_sequencer
  import ap_ctrl_seq_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WDOG_CYCLES     = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_abort,
  input  logic             sink_ready,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             aborted,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic             err_spurious,
  output logic             err_timeout
);

  localparam int               OUT_W   = clog2_outstanding(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  // NOTE: reset asserts asynchronously but is released on a clock edge to avoid recovery violations.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  seq_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             aborted_q, err_spurious_q, err_timeout_q;
  logic             active, launch, issue, complete, spurious, last_issue, wdog_hit;

  assign active      = (state_q == RUN) || (state_q == DRAIN);
  assign launch      = (state_q == IDLE) && cfg_start;
  assign ap_continue = active && sink_ready;
  assign complete    = ap_done && ap_continue && (outstanding_q != '0);
  // A done with nothing in flight is an error in any state, even when not acknowledged.
  assign spurious    = ap_done && (outstanding_q == '0);
  assign ap_start    = (state_q == RUN) && (issued_cnt < count_q) &&
                       (outstanding_q < OUT_MAX) && !cfg_abort && !wdog_hit;
  assign issue       = ap_start && ap_ready;
  assign last_issue  = issue && (issued_cnt == count_q - CNT_W'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !complete)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!issue && complete) outstanding_d = outstanding_q - OUT_W'(1);
  end

  ap_ctrl_txn_counter #(.W(CNT_W)) u_issued (
    .clock (clock),
    .reset (rst_int),
    .clr_i (launch),
    .en_i  (issue),
    .max_i (count_q),
    .cnt_o (issued_cnt)
  );

  ap_ctrl_txn_counter #(.W(CNT_W)) u_done (
    .clock (clock),
    .reset (rst_int),
    .clr_i (launch),
    .en_i  (complete),
    .max_i (issued_cnt),
    .cnt_o (done_cnt)
  );

`ifdef AP_CTRL_SEQ_WATCHDOG_EN
  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_run;

  assign wdog_run = active && (outstanding_q != '0);

  ap_ctrl_txn_counter #(.W(CNT_W)) u_wdog (
    .clock (clock),
    .reset (rst_int),
    .clr_i (!wdog_run || complete),
    .en_i  (wdog_run),
    .max_i (CNT_W'(WDOG_CYCLES - 1)),
    .cnt_o (wdog_cnt)
  );

  // Fires on the WDOG_CYCLES-th consecutive cycle with work in flight and no completion.
  assign wdog_hit = wdog_run && !complete && (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0 & (WDOG_CYCLES > 0);
`endif

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state_q        <= IDLE;
      count_q        <= '0;
      outstanding_q  <= '0;
      aborted_q      <= 1'b0;
      err_spurious_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (spurious) err_spurious_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            count_q   <= cfg_count;
            aborted_q <= 1'b0;
            state_q   <= (cfg_count == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (wdog_hit) begin
            err_timeout_q <= 1'b1;
            aborted_q     <= 1'b1;
            state_q       <= FIN;
          end else if (cfg_abort) begin
            aborted_q <= (issued_cnt < count_q);
            state_q   <= DRAIN;
          end else if (last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wdog_hit) begin
            err_timeout_q <= 1'b1;
            aborted_q     <= 1'b1;
            state_q       <= FIN;
          end else if (outstanding_d == '0) begin
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign finish       = (state_q == FIN);
  assign aborted      = aborted_q;
  assign err_spurious = err_spurious_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Randomized + directed bench for ap_ctrl_sequencer against a transaction-level model.
module tb_ap_ctrl_sequencer;

  localparam int CNT_W = 16;
  localparam int MAXO  = 2;
  localparam int WD    = 16;
`ifdef AP_CTRL_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             cfg_abort = 1'b0;
  logic             sink_ready = 1'b1;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_start, ap_continue, busy, finish, aborted, err_spurious, err_timeout;
  logic [CNT_W-1:0] issued_cnt, done_cnt;

  always #5 clock = ~clock;

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO), .WDOG_CYCLES(WD)) dut (
    .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_count(cfg_count),
    .cfg_abort(cfg_abort), .sink_ready(sink_ready), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue), .busy(busy),
    .finish(finish), .aborted(aborted), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
    .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage 0 no run, 1 issuing, 2 waiting for completions, 3 end-of-run pulse.
  int m_stage, m_count, m_issued, m_done, m_out, m_wd, m_hold;
  bit m_aborted, m_spur, m_tmo;
  bit e_active, e_cont, e_cmp, e_hit, e_start, e_iss;
  int p_issued, p_out;

  // Kernel stimulus state
  int cyc = 0;
  int q[$];
  bit k_ready_rand = 0, k_done_en = 0, k_done_rand = 0, k_force_done = 0, s_rand = 0;
  int n_finish = 0, n_start = 0;

  always @(negedge clock) begin
    if (reset) begin
      m_stage = 0; m_count = 0; m_issued = 0; m_done = 0; m_out = 0; m_wd = 0;
      m_aborted = 0; m_spur = 0; m_tmo = 0; m_hold = 2;
      q.delete();
    end
    e_active = (m_stage == 1) || (m_stage == 2);
    e_cont   = e_active && sink_ready;
    e_cmp    = ap_done && e_cont && (m_out > 0);
    e_hit    = WD_EN && e_active && (m_out > 0) && (m_wd == WD - 1) && !e_cmp;
    e_start  = (m_stage == 1) && (m_issued < m_count) && (m_out < MAXO) && !cfg_abort && !e_hit;

    check("ap_start", 32'(ap_start), 32'(e_start));
    check("ap_continue", 32'(ap_continue), 32'(e_cont));
    check("busy", 32'(busy), 32'(m_stage != 0));
    check("finish", 32'(finish), 32'(m_stage == 3));
    check("aborted", 32'(aborted), 32'(m_aborted));
    check("issued_cnt", 32'(issued_cnt), 32'(m_issued));
    check("done_cnt", 32'(done_cnt), 32'(m_done));
    check("err_spurious", 32'(err_spurious), 32'(m_spur));
    check("err_timeout", 32'(err_timeout), 32'(m_tmo));

    if (!reset) begin
      if (m_hold > 0) begin
        m_hold--;
      end else begin
        p_issued = m_issued;
        p_out    = m_out;
        e_iss    = e_start && ap_ready;
        if (ap_done && p_out == 0) m_spur = 1;
        if (e_cmp && m_done < p_issued) m_done++;
        if (e_iss) m_issued++;
        m_out = p_out + int'(e_iss) - int'(e_cmp);
        if (!(e_active && p_out > 0) || e_cmp) m_wd = 0;
        else if (m_wd < WD - 1) m_wd++;
        case (m_stage)
          0: if (cfg_start) begin
               m_count = int'(cfg_count); m_issued = 0; m_done = 0; m_aborted = 0;
               m_stage = (cfg_count == 0) ? 3 : 1;
             end
          1: if (e_hit) begin
               m_stage = 3; m_tmo = 1; m_aborted = 1;
             end else if (cfg_abort) begin
               m_stage = 2; m_aborted = (p_issued < m_count);
             end else if (m_issued == m_count) begin
               m_stage = 2;
             end
          2: if (e_hit) begin
               m_stage = 3; m_tmo = 1; m_aborted = 1;
             end else if (m_out == 0) begin
               m_stage = 3;
             end
          default: m_stage = 0;
        endcase
      end
      if (ap_start && ap_ready) q.push_back(cyc);
      if (ap_done && ap_continue && q.size() > 0) void'(q.pop_front());
      if (finish) n_finish++;
      if (ap_start) n_start++;
    end
  end

  // Kernel: accepts starts, answers each with done at least 2 cycles later.
  always @(posedge clock) begin
    cyc++;
    #2;
    ap_ready = k_ready_rand ? 1'($urandom % 2) : 1'b1;
    ap_done  = k_force_done ||
               (k_done_en && q.size() > 0 && (cyc - q[0] >= 2) && (!k_done_rand || ($urandom % 2 == 0)));
    if (s_rand) sink_ready = ($urandom % 4 != 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int cnt);
    cfg_count = CNT_W'(cnt);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  int snap, abort_at;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_issued", 32'(issued_cnt), 32'd0);

    // Basic run of 3 with done 2 cycles after each start
    k_done_en = 1;
    snap = n_finish;
    start_run(3);
    wait_idle(100, "basic");
    tick();
    check("basic_issued", 32'(issued_cnt), 32'd3);
    check("basic_done", 32'(done_cnt), 32'd3);
    check("basic_finish_pulses", 32'(n_finish - snap), 32'd1);
    check("basic_aborted", 32'(aborted), 32'd0);

    // Outstanding limit: dones withheld
    k_done_en = 0;
    start_run(5);
    tick(6);
    check("limit_issued", 32'(issued_cnt), 32'd2);
    check("limit_start_low", 32'(ap_start), 32'd0);
    k_force_done = 1;
    tick();
    k_force_done = 0;
    check("limit_start_back", 32'(ap_start), 32'd1);
    check("limit_done1", 32'(done_cnt), 32'd1);
    k_done_en = 1;
    wait_idle(200, "limit");
    check("limit_issued_end", 32'(issued_cnt), 32'd5);
    check("limit_done_end", 32'(done_cnt), 32'd5);

    // Zero-length run
    snap = n_start;
    start_run(0);
    check("zero_finish", 32'(finish), 32'd1);
    tick();
    check("zero_busy_after", 32'(busy), 32'd0);
    check("zero_no_start", 32'(n_start - snap), 32'd0);

    // Abort after the 4th issue
    start_run(10);
    for (int i = 0; i < 100; i++) begin
      if (issued_cnt == 3 && ap_start) break;
      tick();
    end
    tick();
    cfg_abort = 1'b1;
    #1;
    check("abort_start_low", 32'(ap_start), 32'd0);
    check("abort_issued", 32'(issued_cnt), 32'd4);
    tick();
    cfg_abort = 1'b0;
    wait_idle(100, "abort");
    check("abort_done", 32'(done_cnt), 32'd4);
    check("abort_flag", 32'(aborted), 32'd1);

    // sink_ready low in DRAIN freezes completions
    k_done_en = 0;
    start_run(2);
    for (int i = 0; i < 20; i++) begin
      if (issued_cnt == 2) break;
      tick();
    end
    sink_ready = 1'b0;
    k_done_en  = 1;
    tick(4);
    check("sink_cont_low", 32'(ap_continue), 32'd0);
    check("sink_done_frozen", 32'(done_cnt), 32'd0);
    check("sink_busy", 32'(busy), 32'd1);
    sink_ready = 1'b1;
    wait_idle(50, "sink");
    check("sink_done_end", 32'(done_cnt), 32'd2);
    check("spur_before", 32'(err_spurious), 32'd0);
    k_force_done = 1;
    tick();
    k_force_done = 0;
    tick();
    check("spur_after", 32'(err_spurious), 32'd1);

`ifdef AP_CTRL_SEQ_WATCHDOG_EN
    k_done_en = 0;
    start_run(3);
    tick(16);
    check("wdog_early", 32'(err_timeout), 32'd0);
    tick();
    check("wdog_timeout", 32'(err_timeout), 32'd1);
    check("wdog_finish", 32'(finish), 32'd1);
    check("wdog_aborted", 32'(aborted), 32'd1);
    k_done_en = 1;
`else
    check("no_wdog_timeout", 32'(err_timeout), 32'd0);
`endif

    // Reset in the middle of a run
    k_done_en = 1;
    start_run(8);
    tick(4);
    #2;
    reset = 1'b1;
    snap = n_finish;
    #1;
    check("arst_start", 32'(ap_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_issued", 32'(issued_cnt), 32'd0);
    check("arst_done", 32'(done_cnt), 32'd0);
    check("arst_spur", 32'(err_spurious), 32'd0);
    check("arst_aborted", 32'(aborted), 32'd0);
    check("arst_timeout", 32'(err_timeout), 32'd0);
    tick();
    reset = 1'b0;
    tick(3);
    check("arst_no_finish", 32'(n_finish - snap), 32'd0);

    // Randomized runs
    k_ready_rand = 1; k_done_rand = 1; s_rand = 1;
    for (int r = 0; r < 30; r++) begin
      abort_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 15)) : -1;
      start_run(int'($urandom_range(0, 12)));
      for (int c = 0; c < 600; c++) begin
        if (!busy) break;
        cfg_abort = (c == abort_at);
        cfg_start = ($urandom % 8 == 0);
        cfg_count = CNT_W'($urandom_range(0, 5));
        tick();
      end
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
      if (busy) check("rand_run_timeout", 32'(busy), 32'd0);
      tick(int'($urandom_range(1, 3)));
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
